// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between execute and a
// 64-bit doubleword data memory. Sub-word stores are done as read-modify-write;
// misaligned or illegal requests are answered without touching memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64   // lane logic below assumes 8 byte lanes
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  // Request fields latched at accept; inputs are don't-care afterwards.
  logic                    r_is_store;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_misaligned;
  logic                    r_illegal;
  logic [DATA_WIDTH-1:0]   r_word;        // doubleword captured in READ

  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_misaligned;
  logic                    w_size_misaligned;
  logic [3:0]              w_size_bytes;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_load;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Stores only have B/H/W/D encodings; loads reserve 111.
  assign w_illegal = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);

  // Natural alignment check on the incoming request.
  always_comb begin
    unique case (req_funct3[1:0])
      2'b01:   w_size_misaligned = req_addr[0];
      2'b10:   w_size_misaligned = |req_addr[1:0];
      2'b11:   w_size_misaligned = |req_addr[2:0];
      default: w_size_misaligned = 1'b0;
    endcase
  end

  // Illegal takes precedence, so an illegal request never also reports misaligned.
  assign w_misaligned = !w_illegal && w_size_misaligned;

  assign w_size_bytes = 4'd1 << r_funct3[1:0];
  assign mem_address  = {r_addr[ADDR_WIDTH-1:3], 3'b000};

  // Byte-lane merge for sub-word stores: lane g takes source byte (g - offset)
  // when that falls inside the access size, otherwise keeps the memory byte.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic [2:0] w_src;
    assign w_src = 3'(g) - r_addr[2:0];
    assign w_merged[8*g +: 8] = ({1'b0, w_src} < w_size_bytes) ? r_wdata[8*w_src +: 8]
                                                                : r_word[8*g +: 8];
  end

  assign w_shifted = r_word >> {r_addr[2:0], 3'b000};

  // Extract and sign/zero-extend the addressed field of the captured word.
  always_comb begin
    unique case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b011:  w_load = w_shifted;
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}},  w_shifted[7:0]};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_load = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
      default: w_load = '0;
    endcase
  end

  // State register; reset drops any in-flight operation.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Request latches and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_word       <= '0;
    end else begin
      if (w_accept) begin
        r_is_store   <= req_is_store;
        r_funct3     <= req_funct3;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        r_misaligned <= w_misaligned;
        r_illegal    <= w_illegal;
      end
      if (r_state == S_READ) r_word <= mem_read_data;
    end
  end

  // Next-state and output decode from state and latched request.
  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next_state    = r_state;
    req_ready       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_write_data  = '0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_illegal || w_misaligned)
            w_next_state = S_RESP;
          else if (req_is_store && (req_funct3[1:0] == 2'b11))
            w_next_state = S_WRITE;   // full doubleword needs no read
          else
            w_next_state = S_READ;
        end
      end
      S_READ: begin
        mem_read     = 1'b1;
        w_next_state = r_is_store ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_write_data = (r_funct3[1:0] == 2'b11) ? r_wdata : w_merged;
        w_next_state   = S_RESP;
      end
      S_RESP: begin
        resp_valid      = 1'b1;
        resp_misaligned = r_misaligned;
        resp_illegal    = r_illegal;
        resp_rdata      = (r_is_store || r_illegal || r_misaligned) ? '0 : w_load;
        w_next_state    = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural data memory, byte-level reference
// model and a scoreboard queue compared on each resp_valid pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_illegal    (resp_illegal)
  );

  // Data memory: combinational read, write on posedge.
  logic [63:0] dmem    [0:31] = '{default: '0};
  logic [63:0] ref_mem [0:31] = '{default: '0};
  assign mem_read_data = dmem[mem_address[7:0] >> 3];
  always @(posedge clk) if (mem_write) dmem[mem_address[7:0] >> 3] <= mem_write_data;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_rd = 0, n_wr = 0, n_acc = 0, n_resp = 0, n_ready_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts bus activity and scores each response.
  exp_t e_mon;
  always @(negedge clk) begin
    if (mem_read)  n_rd++;
    if (mem_write) n_wr++;
    if (req_valid && req_ready && !reset) n_acc++;
    if ((mem_read || mem_write || resp_valid) && req_ready) n_ready_bad++;
    if (resp_valid) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e_mon = sb_q.pop_front();
        check("rdata",      resp_rdata,            e_mon.rdata);
        check("misaligned", 64'(resp_misaligned),  64'(e_mon.mis));
        check("illegal",    64'(resp_illegal),     64'(e_mon.ill));
        check("latency",    64'(cyc - e_mon.acc),  64'(e_mon.lat));
      end
    end
  end

  // Byte-level reference: computes expected response and updates ref_mem.
  task automatic model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output exp_t e);
    int size;
    int off;
    logic [63:0] w;
    logic [63:0] v;
    size    = 1 << f3[1:0];
    off     = int'(a[2:0]);
    e.ill   = st ? (f3 >= 3'd4) : (f3 == 3'd7);
    e.mis   = !e.ill && ((off % size) != 0);
    e.rdata = '0;
    e.lat   = 1;
    e.acc   = 0;
    if (!e.ill && !e.mis) begin
      w = ref_mem[a[7:3]];
      if (st) begin
        for (int k = 0; k < size; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
        ref_mem[a[7:3]] = w;
        e.lat = (size == 8) ? 2 : 3;
      end else begin
        v = '0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
          for (int k = size; k < 8; k++) v[8*k +: 8] = 8'hFF;
        e.rdata = v;
        e.lat   = 2;
      end
    end
  endtask

  // Present one request; hold keeps req_valid high after acceptance.
  task automatic send(input logic st, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input bit hold);
    exp_t e;
    int n = 0;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    model(st, f3, a, wd, e);
    e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Wait for every queued response, bounded.
  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int w0, r0, a0, p0, b0;
  logic [63:0] saved;

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = '0;
    req_addr     = '0;
    req_wdata    = '0;
    #12;
    check("rst_ready",     64'(req_ready),  64'd1);
    check("rst_resp",      64'({resp_valid, resp_misaligned, resp_illegal}), 64'd0);
    check("rst_mem_ctl",   64'({mem_read, mem_write}), 64'd0);
    check("rst_mem_addr",  mem_address,     64'd0);
    check("rst_mem_wdata", mem_write_data,  64'd0);
    check("rst_rdata",     resp_rdata,      64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // SD then LD round trip
    send(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b0); drain();
    send(1'b0, 3'b011, 64'h10, 64'h0, 1'b0);                drain();

    // SB read-modify-write, single write pulse
    w0 = n_wr;
    send(1'b1, 3'b000, 64'h13, 64'hAB, 1'b0); drain();
    check("sb_write_pulses", 64'(n_wr - w0), 64'd1);
    send(1'b0, 3'b011, 64'h10, 64'h0, 1'b0);  drain();

    // Sub-word loads with sign/zero extension
    send(1'b0, 3'b000, 64'h13, 64'h0, 1'b0); drain();
    send(1'b0, 3'b100, 64'h13, 64'h0, 1'b0); drain();
    send(1'b0, 3'b001, 64'h12, 64'h0, 1'b0); drain();
    send(1'b0, 3'b110, 64'h14, 64'h0, 1'b0); drain();
    send(1'b0, 3'b010, 64'h14, 64'h0, 1'b0); drain();

    // SH in the top half keeps other lanes
    send(1'b1, 3'b001, 64'h16, 64'hFFFF_FFFF_FFFF_8001, 1'b0); drain();
    send(1'b0, 3'b011, 64'h10, 64'h0, 1'b0); drain();

    // Misaligned / illegal never touch memory
    r0 = n_rd;
    send(1'b0, 3'b010, 64'h12, 64'h0, 1'b0); drain();
    send(1'b0, 3'b101, 64'h13, 64'h0, 1'b0); drain();
    send(1'b0, 3'b111, 64'h10, 64'h0, 1'b0); drain();
    check("err_no_read", 64'(n_rd - r0), 64'd0);
    w0 = n_wr;
    send(1'b1, 3'b100, 64'h10, 64'hDEAD, 1'b0); drain();
    send(1'b1, 3'b011, 64'h14, 64'hDEAD, 1'b0); drain();
    check("err_no_write", 64'(n_wr - w0), 64'd0);

    // Reset in the middle of an SW write phase
    send(1'b1, 3'b011, 64'h18, 64'hCAFEBABE_DEADBEEF, 1'b0); drain();
    saved = ref_mem[3];
    send(1'b1, 3'b010, 64'h18, 64'h12345678, 1'b0);
    for (int n = 0; n < 10 && !mem_write; n++) @(negedge clk);
    check("sw_in_write", 64'(mem_write), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_write_drop", 64'({mem_read, mem_write}), 64'd0);
    check("rst_addr_zero",  mem_address,    64'd0);
    check("rst_wdata_zero", mem_write_data, 64'd0);
    check("rst_ready_high", 64'(req_ready), 64'd1);
    sb_q.delete();
    ref_mem[3] = saved;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1'b0, 3'b011, 64'h18, 64'h0, 1'b0); drain();

    // Back-to-back with req_valid held high
    a0 = n_acc; p0 = n_resp; b0 = n_ready_bad;
    send(1'b1, 3'b011, 64'h20, 64'h8877665544332211, 1'b1);
    send(1'b0, 3'b011, 64'h20, 64'h0,                1'b1);
    send(1'b1, 3'b001, 64'h22, 64'h0000_0000_0000_F00D, 1'b1);
    send(1'b0, 3'b010, 64'h22, 64'h0,                1'b1);
    send(1'b0, 3'b110, 64'h20, 64'h0,                1'b1);
    send(1'b0, 3'b000, 64'h23, 64'h0,                1'b0);
    drain();
    check("b2b_accepts",   64'(n_acc - a0),        64'd6);
    check("b2b_responses", 64'(n_resp - p0),       64'd6);
    check("b2b_ready_low", 64'(n_ready_bad - b0),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
